// File: rtl/stream_merge_pkg.sv
// Shared types and helpers for the N:1 stream merge and its arbiter.
package stream_merge_pkg;

  // Arbitration policy selector.
  typedef enum logic {
    ARB_FIXED       = 1'b0,  // lowest requesting index wins
    ARB_ROUND_ROBIN = 1'b1   // search starts at the rotating pointer
  } arb_mode_t;

  // Index that follows idx in a ring of 'ports' entries.
  function automatic int wrap_next(input int idx, input int ports);
    return (idx >= ports - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_merge_arbiter.sv
// PORTS-wide request -> one-hot grant plus encoded index.
// Owns the round-robin pointer, which moves only on the 'advance' strobe,
// so a stalled grant never rotates. Reusable by any N:1 block.
module stream_merge_arbiter
  import stream_merge_pkg::*;
#(
  parameter int        PORTS    = 2,
  parameter int        ID_WIDTH = $clog2(PORTS),
  parameter arb_mode_t ARB_MODE = ARB_ROUND_ROBIN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    req,
  input  logic                advance,
  output logic [PORTS-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic [ID_WIDTH-1:0] ptr;
  logic                found;
  int                  cand;

  // Priority search: from index 0 (fixed) or from ptr with wrap (round robin).
  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < PORTS; i++) begin
      cand = (ARB_MODE == ARB_FIXED) ? i : int'(ptr) + i;
      if (cand >= PORTS) cand = cand - PORTS;
      if (!found && req[cand]) begin
        found           = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = ID_WIDTH'(cand);
      end
    end
  end

  // Pointer moves past the port that just transferred; held otherwise.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ID_WIDTH'(wrap_next(int'(grant_idx), PORTS));
    end
  end

endmodule

// File: rtl/stream_merge.sv
// N-to-1 stream merge. Arbitrates PORTS input streams onto one output stream
// and tags each beat with the index of its source port so a downstream split
// can route responses back. Streams are flattened: port k's payload occupies
// stream_in_data[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH].
module stream_merge
  import stream_merge_pkg::*;
#(
  parameter int        PORTS         = 2,
  parameter int        PAYLOAD_WIDTH = 8,
  parameter int        ID_WIDTH      = $clog2(PORTS),
  parameter int        PIPELINE_MODE = 1,
  parameter arb_mode_t ARB_MODE      = ARB_ROUND_ROBIN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORTS-1:0]               stream_in_valid,
  output logic [PORTS-1:0]               stream_in_ready,
  input  logic [PORTS*PAYLOAD_WIDTH-1:0] stream_in_data,
  output logic                           stream_out_valid,
  input  logic                           stream_out_ready,
  output logic [PAYLOAD_WIDTH-1:0]       stream_out_data,
  output logic [ID_WIDTH-1:0]            stream_out_id
);

  // Elaboration-time parameter sanity.
  if (PORTS < 2) begin : g_bad_ports
    $error("stream_merge: PORTS must be greater than 1");
  end
  if (ID_WIDTH < $clog2(PORTS)) begin : g_bad_id_width
    $error("stream_merge: ID_WIDTH too narrow for PORTS");
  end

  // Beat carried by the output stage: source index plus payload.
  typedef struct packed {
    logic [ID_WIDTH-1:0]      id;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } beat_t;

  logic [PORTS-1:0]         grant;
  logic [ID_WIDTH-1:0]      grant_idx;
  logic [PAYLOAD_WIDTH-1:0] sel_payload;
  logic                     stage_ready;
  logic                     transfer;
  beat_t                    in_beat;

  stream_merge_arbiter #(
    .PORTS    (PORTS),
    .ID_WIDTH (ID_WIDTH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (stream_in_valid),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // AND-OR mux of the granted payload; non-granted payloads never reach ready.
  always_comb begin
    sel_payload = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (grant[k]) sel_payload = sel_payload | stream_in_data[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    end
  end

  // Only the granted port sees ready, and only when the stage can accept.
  assign stream_in_ready = rst ? '0 : (grant & {PORTS{stage_ready}});
  assign transfer        = |(stream_in_valid & stream_in_ready);
  assign in_beat         = '{id: grant_idx, payload: sel_payload};

  if (PIPELINE_MODE != 0) begin : g_reg
    logic  out_valid_q;
    beat_t beat_q;

    // Registered stage: full throughput because a drained beat frees the slot
    // in the same cycle.
    assign stage_ready = !out_valid_q || stream_out_ready;

    // Output register: loads on a transfer, holds while the sink stalls.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        beat_q      <= '0;
      end else if (stage_ready) begin
        out_valid_q <= transfer;
        if (transfer) beat_q <= in_beat;
      end
    end

    assign stream_out_valid = out_valid_q;
    assign stream_out_id    = beat_q.id;
    assign stream_out_data  = beat_q.payload;
  end else begin : g_comb
    // Combinational pass: the granted beat appears on the output the same cycle.
    assign stage_ready      = stream_out_ready;
    assign stream_out_valid = !rst && (|(stream_in_valid & grant));
    assign stream_out_id    = rst ? '0 : in_beat.id;
    assign stream_out_data  = in_beat.payload;
  end

endmodule

// File: tb/tb_stream_merge.sv
// Directed bench for stream_merge: a 4-port round-robin registered instance
// and a 3-port fixed-priority combinational instance.
module tb_stream_merge;
  import stream_merge_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance A: PORTS=4, round robin, registered output.
  logic [3:0]  a_in_valid, a_in_ready;
  logic [31:0] a_in_data;
  logic        a_out_valid, a_out_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_id;

  // Instance B: PORTS=3, fixed priority, combinational pass.
  logic [2:0]  b_in_valid, b_in_ready;
  logic [23:0] b_in_data;
  logic        b_out_valid, b_out_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_id;

  stream_merge #(
    .PORTS(4), .PAYLOAD_WIDTH(8), .ID_WIDTH(2),
    .PIPELINE_MODE(1), .ARB_MODE(ARB_ROUND_ROBIN)
  ) u_a (
    .clk(clk), .rst(rst),
    .stream_in_valid(a_in_valid), .stream_in_ready(a_in_ready),
    .stream_in_data(a_in_data),
    .stream_out_valid(a_out_valid), .stream_out_ready(a_out_ready),
    .stream_out_data(a_out_data), .stream_out_id(a_out_id)
  );

  stream_merge #(
    .PORTS(3), .PAYLOAD_WIDTH(8), .ID_WIDTH(2),
    .PIPELINE_MODE(0), .ARB_MODE(ARB_FIXED)
  ) u_b (
    .clk(clk), .rst(rst),
    .stream_in_valid(b_in_valid), .stream_in_ready(b_in_ready),
    .stream_in_data(b_in_data),
    .stream_out_valid(b_out_valid), .stream_out_ready(b_out_ready),
    .stream_out_data(b_out_data), .stream_out_id(b_out_id)
  );

  int tests = 0;
  int fails = 0;
  int a_cnt [4];

  // Port k of A offers 0x10*(k+1) + (number of beats it has already sent).
  task automatic set_a_data();
    for (int k = 0; k < 4; k++) a_in_data[k*8 +: 8] = 8'(8'h10 * (k + 1) + a_cnt[k]);
  endtask

  // One clock: record A handshakes before the edge, advance A's payloads after.
  task automatic tick();
    logic [3:0] acc;
    #1;
    acc = a_in_valid & a_in_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (acc[k]) a_cnt[k]++;
    set_a_data();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [1:0] id, input logic [7:0] data);
    check({tag, " a_valid"}, 32'(a_out_valid), 32'd1);
    check({tag, " a_id"},    32'(a_out_id),    32'(id));
    check({tag, " a_data"},  32'(a_out_data),  32'(data));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) a_cnt[k] = 0;
    rst         = 1'b1;
    a_in_valid  = 4'hF;
    a_out_ready = 1'b1;
    b_in_valid  = 3'b111;
    b_out_ready = 1'b1;
    b_in_data   = {8'hB2, 8'hB1, 8'hB0};
    set_a_data();

    // 1: reset held three cycles with every input valid.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst a_ready", 32'(a_in_ready),  32'h0);
      check("rst a_valid", 32'(a_out_valid), 32'h0);
      check("rst a_id",    32'(a_out_id),    32'h0);
      check("rst b_ready", 32'(b_in_ready),  32'h0);
      check("rst b_valid", 32'(b_out_valid), 32'h0);
      check("rst b_id",    32'(b_out_id),    32'h0);
    end
    rst = 1'b0;
    #1;
    check("post-rst a_ready", 32'(a_in_ready),  32'h1);
    check("post-rst a_valid", 32'(a_out_valid), 32'h0);

    // 2: all four ports valid, sink always ready -> ids 0,1,2,3,0,1,2,3.
    for (int n = 0; n < 8; n++) begin
      tick();
      check_a("rr", 2'(n % 4), 8'(8'h10 * (n % 4 + 1) + n / 4));
      check("rr a_ready", 32'(a_in_ready), 32'(4'b0001 << ((n + 1) % 4)));
    end

    // 3: walk the pointer to 2, then only ports 1 and 3 valid -> 3,1,3,1.
    a_in_valid = 4'b0011;
    tick(); check_a("ptr0", 2'd0, 8'h12);
    tick(); check_a("ptr1", 2'd1, 8'h22);
    a_in_valid = 4'b1010;
    #1;
    check("skip a_ready", 32'(a_in_ready), 32'h8);
    tick(); check_a("skip 3a", 2'd3, 8'h42);
    check("wrap ptr0 a_ready", 32'(a_in_ready), 32'h2);
    tick(); check_a("skip 1a", 2'd1, 8'h23);
    tick(); check_a("skip 3b", 2'd3, 8'h43);
    tick(); check_a("skip 1b", 2'd1, 8'h24);

    // 4: load a port-2 beat, then stall the sink for five cycles.
    a_in_valid = 4'hF;
    #1;
    check("bp grant2", 32'(a_in_ready), 32'h4);
    tick(); check_a("bp load", 2'd2, 8'h32);
    a_out_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("bp a_ready", 32'(a_in_ready), 32'h0);
      tick();
      check_a("bp hold", 2'd2, 8'h32);
    end
    a_out_ready = 1'b1;
    #1;
    check("bp resume ready", 32'(a_in_ready), 32'h8);
    tick(); check_a("bp resume", 2'd3, 8'h44);

    // Drain: no valid inputs -> output falls, pointer held at 0.
    a_in_valid = 4'h0;
    tick(); check("drain valid1", 32'(a_out_valid), 32'h0);
    tick(); check("drain valid2", 32'(a_out_valid), 32'h0);
    a_in_valid = 4'hF;
    #1;
    check("drain ptr held", 32'(a_in_ready), 32'h1);

    // 5: fixed priority, ports 0 and 2 valid -> only port 0 served.
    b_in_valid = 3'b101;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("fix b_ready", 32'(b_in_ready),  32'h1);
      check("fix b_valid", 32'(b_out_valid), 32'h1);
      check("fix b_id",    32'(b_out_id),    32'h0);
      check("fix b_data",  32'(b_out_data),  32'hB0);
      tick();
    end
    b_in_valid = 3'b100;
    #1;
    check("fix2 b_ready", 32'(b_in_ready), 32'h4);
    check("fix2 b_id",    32'(b_out_id),   32'h2);
    check("fix2 b_data",  32'(b_out_data), 32'hB2);
    b_out_ready = 1'b0;
    #1;
    check("fix stall b_ready", 32'(b_in_ready),  32'h0);
    check("fix stall b_valid", 32'(b_out_valid), 32'h1);
    check("fix stall b_id",    32'(b_out_id),    32'h2);
    b_in_valid = 3'b000;
    #1;
    check("fix idle b_valid", 32'(b_out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
